pdetect_stream: RTL and testbench
=================================

// Module: pdetect_stream
// PURPOSE
//  Parametrised stream pattern detector: matches a runtime-loadable DEPTH-beat pattern
//  on a valid-qualified DATA_W-bit stream; pulses a flag and counts matches.
//  Sits on ingress byte/word streams as a framing/sync-word finder.
//  Replaces the fixed 8-bit x 4-beat detector.
// PARAMETERS
//  DATA_W        8             beat width, bits (>=1)
//  DEPTH         4             pattern length, beats (>=2)
//  CNT_W         16            match counter width (>=1)
//  PATTERN_RST   32'h0A0B0C0D  pattern after reset, DEPTH*DATA_W bits; oldest beat in MSBs
// PORTS
//  i_clk          in   1              clock
//  i_rst          in   1              synchronous, active-high reset
//  i_valid        in   1              i_data carries a beat this cycle
//  i_data         in   DATA_W         stream beat
//  i_cfg_we       in   1              load i_cfg_pattern (and i_cfg_mask)
//  i_cfg_pattern  in   DEPTH*DATA_W   new pattern, oldest beat in MSBs
//  i_cfg_mask     in   DEPTH*DATA_W   compare mask (PDETECT_MASK_EN only)
//  i_overlap      in   1              1: overlapping matches allowed; 0: history restarts after match
//  i_clr_cnt      in   1              clear match counter
//  o_detected     out  1              registered 1-cycle match pulse
//  o_match_cnt    out  CNT_W          saturating match count
//  o_armed        out  1              history holds >= DEPTH-1 beats (next valid beat can match)
// BEHAVIOUR
//  - Reset: history 0, pattern=PATTERN_RST, mask all-1, fill=0, o_detected=0,
//    o_match_cnt=0, o_armed=0. Reset mid-stream discards partial history.
//  - History shifts only when i_valid=1; idle cycles hold history, fill, armed.
//  - Fill counter 0..DEPTH-1: FILLING (fill<DEPTH-1) / ARMED (fill==DEPTH-1); o_armed=ARMED.
//    Valid beat in FILLING: fill+1. ARMED is terminal until match (overlap=0), cfg write, reset.
//  - Match candidate = {history[DEPTH-2:0], i_data}; hit = i_valid & ARMED & compare.
//    Prevents false hits from reset-zero history (e.g. all-zero pattern).
//  - o_detected registered: high exactly the cycle after the accepting edge; else 0.
//    Back-to-back hits give consecutive pulses.
//  - i_overlap=0: on hit, fill->0 (next match needs DEPTH fresh beats).
//    i_overlap=1: stay ARMED.
//  - Counter: hit -> +1, saturates at 2**CNT_W-1. i_clr_cnt -> 0;
//    i_clr_cnt with hit same cycle -> 1.
//  - i_cfg_we: pattern/mask load at edge; fill->0; no hit evaluated that cycle;
//    a same-cycle valid beat is still shifted in but not counted toward fill.
//  - Priority: i_rst > i_cfg_we > hit/shift.
// CONFIGURATION
//  PDETECT_MASK_EN defined: i_cfg_mask port + mask register present;
//    compare = ((cand ^ pattern) & mask) == 0; mask bit 0 = don't care; mask resets all-1.
//  PDETECT_MASK_EN undefined: no i_cfg_mask port, no mask register;
//    compare = (cand == pattern).
// STRUCTURE
//  pdetect_pkg: fill_state_e {FILLING, ARMED}; function fill_w(DEPTH) = $clog2(DEPTH).
//  Sub-module pdetect_shreg (DATA_W, DEPTH): valid-gated shift register,
//    sync reset to 0, exposes flat history.
//  Top holds pattern/mask regs, fill FSM, compare, counter, output register.
// TESTING
//  1 Defaults; reset then valid 0A,0B,0C,0D back-to-back -> o_detected 1 cycle after 0D edge; cnt=1.
//  2 0A,idle,0B,idle,idle,0C,0D -> exactly one pulse after 0D; 0A,0B,0C,0E -> no pulse.
//  3 cfg 0x01010101; seven valid 01: i_overlap=1 -> 4 pulses; i_overlap=0 -> 1 pulse.
//  4 cfg 0x00000000 after reset; three 00 -> no pulse, o_armed=1; fourth 00 -> pulse.
//  5 CNT_W=2: 5 hits -> cnt=3 (saturated); i_clr_cnt with hit -> cnt=1; cfg write mid-pattern -> no hit.
//  6 MASK_EN, mask 0xFF00FFFF: 0A,55,0C,0D -> pulse; macro undefined -> no pulse.

Source files
------------

// File: rtl/pdetect_pkg.sv
// pdetect_pkg: shared types and helpers for the stream pattern detector.
//   fill_state_e : history fill state (FILLING while fewer than DEPTH-1 beats are held,
//                  ARMED once the next valid beat can complete a match)
//   fill_w()     : width of the fill counter for a given pattern depth
// Optional feature macro used by this block: PDETECT_MASK_EN (per-bit compare mask).
package pdetect_pkg;

  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } fill_state_e;

  function automatic int fill_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pdetect_stream_if.sv
// pdetect_stream_if: stream, configuration and status signals of pdetect_stream.
//   i_valid / i_data            valid-qualified stream beat
//   i_cfg_we / i_cfg_pattern    pattern load strobe and value (oldest beat in MSBs)
//   i_cfg_mask                  compare mask, only when PDETECT_MASK_EN is defined
//   i_overlap / i_clr_cnt       overlap mode, match-counter clear
//   o_detected / o_match_cnt / o_armed  status from the detector
// master: the side driving the stream; slave: the detector.
interface pdetect_stream_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
);
  logic                    i_valid;
  logic [DATA_W-1:0]       i_data;
  logic                    i_cfg_we;
  logic [DEPTH*DATA_W-1:0] i_cfg_pattern;
`ifdef PDETECT_MASK_EN
  logic [DEPTH*DATA_W-1:0] i_cfg_mask;
`endif
  logic                    i_overlap;
  logic                    i_clr_cnt;
  logic                    o_detected;
  logic [CNT_W-1:0]        o_match_cnt;
  logic                    o_armed;

  modport master (
`ifdef PDETECT_MASK_EN
    output i_cfg_mask,
`endif
    output i_valid, i_data, i_cfg_we, i_cfg_pattern, i_overlap, i_clr_cnt,
    input  o_detected, o_match_cnt, o_armed
  );

  modport slave (
`ifdef PDETECT_MASK_EN
    input  i_cfg_mask,
`endif
    input  i_valid, i_data, i_cfg_we, i_cfg_pattern, i_overlap, i_clr_cnt,
    output o_detected, o_match_cnt, o_armed
  );

endinterface

// File: rtl/pdetect_shreg.sv
// pdetect_shreg: valid-gated history shift register for the pattern detector.
// Holds the last DEPTH-1 beats; the beat arriving this cycle completes the
// DEPTH-beat candidate in the parent, so it is not stored here yet.
//   i_clk, i_rst   clock, synchronous active-high reset (history -> 0)
//   i_valid        shift i_data in this cycle
//   i_data         incoming beat
//   o_history      flat history, oldest beat in MSBs
module pdetect_shreg #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  input  logic [DATA_W-1:0]           i_data,
  output logic [(DEPTH-1)*DATA_W-1:0] o_history
);

  logic [(DEPTH-1)*DATA_W-1:0] hist_q;

  generate
    if (DEPTH == 2) begin : g_single
      always_ff @(posedge i_clk) begin
        if (i_rst)        hist_q <= '0;
        else if (i_valid) hist_q <= i_data;
      end
    end else begin : g_multi
      always_ff @(posedge i_clk) begin
        if (i_rst)        hist_q <= '0;
        else if (i_valid) hist_q <= {hist_q[(DEPTH-2)*DATA_W-1:0], i_data};
      end
    end
  endgenerate

  assign o_history = hist_q;

endmodule

// File: rtl/pdetect_stream.sv
// pdetect_stream: runtime-loadable DEPTH-beat pattern detector on a valid-qualified
// DATA_W-bit stream (framing / sync-word finder). Pulses o_detected one cycle after
// the beat that completes a match and keeps a saturating match count.
//   i_clk, i_rst   clock, synchronous active-high reset
//   bus            pdetect_stream_if.slave (stream, config, status)
// Build option: PDETECT_MASK_EN adds i_cfg_mask and a mask register; a mask bit of 0
// makes that pattern bit don't-care. Without it the compare is exact.
module pdetect_stream
  import pdetect_pkg::*;
#(
  parameter int                          DATA_W      = 8,
  parameter int                          DEPTH       = 4,
  parameter int                          CNT_W       = 16,
  parameter logic [DEPTH*DATA_W-1:0]     PATTERN_RST = 32'h0A0B0C0D
) (
  input  logic           i_clk,
  input  logic           i_rst,
  pdetect_stream_if.slave bus
);

  localparam int PW = DEPTH * DATA_W;
  localparam int HW = (DEPTH - 1) * DATA_W;
  localparam int FW = fill_w(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [HW-1:0]    history;
  logic [PW-1:0]    cand;
  logic [PW-1:0]    pattern_q;
`ifdef PDETECT_MASK_EN
  logic [PW-1:0]    mask_q;
`endif
  fill_state_e      state_q;
  logic [FW-1:0]    fill_q;
  logic             detected_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cmp;
  logic             hit;

  pdetect_shreg #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_shreg (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (bus.i_valid),
    .i_data    (bus.i_data),
    .o_history (history)
  );

  assign cand = {history, bus.i_data};

`ifdef PDETECT_MASK_EN
  assign cmp = (((cand ^ pattern_q) & mask_q) == '0);
`else
  assign cmp = (cand == pattern_q);
`endif

  // Requiring ARMED keeps the zeroed post-reset history from matching an all-zero
  // pattern; a config write suppresses the compare against the outgoing pattern.
  assign hit = bus.i_valid && (state_q == ARMED) && cmp && !bus.i_cfg_we;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pattern_q  <= PATTERN_RST;
`ifdef PDETECT_MASK_EN
      mask_q     <= '1;
`endif
      state_q    <= FILLING;
      fill_q     <= '0;
      detected_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      detected_q <= hit;

      if (bus.i_clr_cnt)
        cnt_q <= hit ? CNT_W'(1) : '0;
      else if (hit && (cnt_q != CNT_MAX))
        cnt_q <= cnt_q + CNT_W'(1);

      // A beat shifted in during a config write is kept in history but does not
      // count toward fill, so the new pattern always needs DEPTH fresh beats.
      if (bus.i_cfg_we) begin
        pattern_q <= bus.i_cfg_pattern;
`ifdef PDETECT_MASK_EN
        mask_q    <= bus.i_cfg_mask;
`endif
        state_q   <= FILLING;
        fill_q    <= '0;
      end else if (hit && !bus.i_overlap) begin
        state_q <= FILLING;
        fill_q  <= '0;
      end else if (bus.i_valid && (state_q == FILLING)) begin
        if (fill_q == FW'(DEPTH - 2))
          state_q <= ARMED;
        fill_q <= fill_q + FW'(1);
      end
    end
  end

  assign bus.o_detected  = detected_q;
  assign bus.o_match_cnt = cnt_q;
  assign bus.o_armed     = (state_q == ARMED);

endmodule

// File: tb/tb_pdetect_stream.sv
module tb_pdetect_stream;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic        cfg_we;
    logic [31:0] pat;
    logic        ovl;
    logic        clr;
    logic        det;
    logic        arm;
    logic [15:0] cnt;
  } vec_t;

  logic i_clk;
  logic i_rst;
  int   n_chk;
  int   n_fail;
  vec_t vecs[$];

  pdetect_stream_if #(.DATA_W(8), .DEPTH(4), .CNT_W(16)) bus ();
  pdetect_stream_if #(.DATA_W(8), .DEPTH(4), .CNT_W(2))  bus_s ();

  pdetect_stream #(.DATA_W(8), .DEPTH(4), .CNT_W(16), .PATTERN_RST(32'h0A0B0C0D)) u_dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  pdetect_stream #(.DATA_W(8), .DEPTH(4), .CNT_W(2), .PATTERN_RST(32'h0A0B0C0D)) u_sat (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus_s)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [7:0] d, input logic we,
                       input logic [31:0] pat, input logic [31:0] msk, input logic ovl,
                       input logic clr);
    i_rst               = rst;
    bus.i_valid         = v;     bus_s.i_valid       = v;
    bus.i_data          = d;     bus_s.i_data        = d;
    bus.i_cfg_we        = we;    bus_s.i_cfg_we      = we;
    bus.i_cfg_pattern   = pat;   bus_s.i_cfg_pattern = pat;
    bus.i_overlap       = ovl;   bus_s.i_overlap     = ovl;
    bus.i_clr_cnt       = clr;   bus_s.i_clr_cnt     = clr;
`ifdef PDETECT_MASK_EN
    bus.i_cfg_mask      = msk;   bus_s.i_cfg_mask    = msk;
`else
    if (msk == 32'h0) begin end
`endif
    @(posedge i_clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic v, input logic [7:0] d, input logic we,
                     input logic [31:0] pat, input logic ovl, input logic clr,
                     input logic det, input logic arm, input logic [15:0] cnt);
    vec_t t;
    t.rst = rst; t.valid = v; t.data = d; t.cfg_we = we; t.pat = pat;
    t.ovl = ovl; t.clr = clr; t.det = det; t.arm = arm; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  initial begin
    logic [15:0] exp_sat;
    n_chk  = 0;
    n_fail = 0;

    // rst v  data   we pattern        ov clr  det arm cnt
    add(1, 0, 8'h00, 0, 32'h0,         0, 0,   0, 0, 0);   // reset state
    add(0, 1, 8'h0A, 0, 32'h0,         0, 0,   0, 0, 0);   // back-to-back 0A..0D
    add(0, 1, 8'h0B, 0, 32'h0,         0, 0,   0, 0, 0);
    add(0, 1, 8'h0C, 0, 32'h0,         0, 0,   0, 1, 0);
    add(0, 1, 8'h0D, 0, 32'h0,         0, 0,   1, 0, 1);
    add(0, 0, 8'h00, 0, 32'h0,         0, 0,   0, 0, 1);
    add(0, 1, 8'h0A, 0, 32'h0,         0, 0,   0, 0, 1);   // idles interleaved
    add(0, 0, 8'hFF, 0, 32'h0,         0, 0,   0, 0, 1);
    add(0, 1, 8'h0B, 0, 32'h0,         0, 0,   0, 0, 1);
    add(0, 0, 8'h0D, 0, 32'h0,         0, 0,   0, 0, 1);
    add(0, 0, 8'h00, 0, 32'h0,         0, 0,   0, 0, 1);
    add(0, 1, 8'h0C, 0, 32'h0,         0, 0,   0, 1, 1);
    add(0, 1, 8'h0D, 0, 32'h0,         0, 0,   1, 0, 2);
    add(0, 1, 8'h0A, 0, 32'h0,         0, 0,   0, 0, 2);   // 0A,0B,0C,0E: no match
    add(0, 1, 8'h0B, 0, 32'h0,         0, 0,   0, 0, 2);
    add(0, 1, 8'h0C, 0, 32'h0,         0, 0,   0, 1, 2);
    add(0, 1, 8'h0E, 0, 32'h0,         0, 0,   0, 1, 2);
    add(0, 0, 8'h00, 0, 32'h0,         0, 0,   0, 1, 2);
    add(1, 0, 8'h00, 0, 32'h0,         0, 0,   0, 0, 0);   // all-zero pattern
    add(0, 0, 8'h00, 1, 32'h00000000,  0, 0,   0, 0, 0);
    add(0, 1, 8'h00, 0, 32'h0,         0, 0,   0, 0, 0);
    add(0, 1, 8'h00, 0, 32'h0,         0, 0,   0, 0, 0);
    add(0, 1, 8'h00, 0, 32'h0,         0, 0,   0, 1, 0);
    add(0, 1, 8'h00, 0, 32'h0,         0, 0,   1, 0, 1);
    add(0, 0, 8'h00, 1, 32'h01010101,  1, 0,   0, 0, 1);   // overlap on, seven 01
    add(0, 1, 8'h01, 0, 32'h0,         1, 0,   0, 0, 1);
    add(0, 1, 8'h01, 0, 32'h0,         1, 0,   0, 0, 1);
    add(0, 1, 8'h01, 0, 32'h0,         1, 0,   0, 1, 1);
    add(0, 1, 8'h01, 0, 32'h0,         1, 0,   1, 1, 2);
    add(0, 1, 8'h01, 0, 32'h0,         1, 0,   1, 1, 3);
    add(0, 1, 8'h01, 0, 32'h0,         1, 0,   1, 1, 4);
    add(0, 1, 8'h01, 0, 32'h0,         1, 0,   1, 1, 5);
    add(0, 0, 8'h00, 0, 32'h0,         1, 0,   0, 1, 5);
    add(0, 0, 8'h00, 1, 32'h01010101,  0, 0,   0, 0, 5);   // overlap off, seven 01
    add(0, 1, 8'h01, 0, 32'h0,         0, 0,   0, 0, 5);
    add(0, 1, 8'h01, 0, 32'h0,         0, 0,   0, 0, 5);
    add(0, 1, 8'h01, 0, 32'h0,         0, 0,   0, 1, 5);
    add(0, 1, 8'h01, 0, 32'h0,         0, 0,   1, 0, 6);
    add(0, 1, 8'h01, 0, 32'h0,         0, 0,   0, 0, 6);
    add(0, 1, 8'h01, 0, 32'h0,         0, 0,   0, 0, 6);
    add(0, 1, 8'h01, 0, 32'h0,         0, 0,   0, 1, 6);
    add(0, 1, 8'h01, 0, 32'h0,         0, 1,   1, 0, 1);   // clear with hit -> 1
    add(0, 0, 8'h00, 0, 32'h0,         0, 1,   0, 0, 0);   // clear alone -> 0
    add(0, 1, 8'h0A, 1, 32'h0A0B0C0D,  0, 0,   0, 0, 0);   // cfg beat not counted
    add(0, 1, 8'h0B, 0, 32'h0,         0, 0,   0, 0, 0);
    add(0, 1, 8'h0C, 0, 32'h0,         0, 0,   0, 0, 0);
    add(0, 1, 8'h0D, 0, 32'h0,         0, 0,   0, 1, 0);
    add(0, 1, 8'h0E, 0, 32'h0,         0, 0,   0, 1, 0);
    add(0, 1, 8'h0A, 0, 32'h0,         0, 0,   0, 1, 0);
    add(0, 1, 8'h0B, 0, 32'h0,         0, 0,   0, 1, 0);
    add(0, 1, 8'h0C, 0, 32'h0,         0, 0,   0, 1, 0);
    add(0, 1, 8'h0D, 1, 32'h0A0B0C0D,  0, 0,   0, 0, 0);   // cfg write blocks a match
    add(0, 1, 8'h0D, 0, 32'h0,         0, 0,   0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].cfg_we, vecs[i].pat,
            32'hFFFFFFFF, vecs[i].ovl, vecs[i].clr);
      exp_sat = (vecs[i].cnt > 16'd3) ? 16'd3 : vecs[i].cnt;
      chk("detected", i, {31'b0, bus.o_detected}, {31'b0, vecs[i].det});
      chk("armed", i, {31'b0, bus.o_armed}, {31'b0, vecs[i].arm});
      chk("match_cnt", i, {16'b0, bus.o_match_cnt}, {16'b0, vecs[i].cnt});
      chk("sat_cnt", i, {30'b0, bus_s.o_match_cnt}, {16'b0, exp_sat});
      chk("sat_detected", i, {31'b0, bus_s.o_detected}, {31'b0, vecs[i].det});
    end

    // Reset mid-stream discards the partial history.
    drive(1, 0, 8'h00, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    drive(0, 1, 8'h0A, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    drive(0, 1, 8'h0B, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    drive(1, 1, 8'h0C, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    chk("midrst_armed", 100, {31'b0, bus.o_armed}, 32'd0);
    drive(0, 1, 8'h0C, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    drive(0, 1, 8'h0D, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    chk("midrst_detected", 101, {31'b0, bus.o_detected}, 32'd0);
    chk("midrst_armed2", 102, {31'b0, bus.o_armed}, 32'd0);
    chk("midrst_cnt", 103, {16'b0, bus.o_match_cnt}, 32'd0);

    // Reset has priority over a config write in the same cycle.
    drive(1, 0, 8'h00, 1, 32'h11111111, 32'hFFFFFFFF, 0, 0);
    drive(0, 1, 8'h0A, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    drive(0, 1, 8'h0B, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    drive(0, 1, 8'h0C, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    drive(0, 1, 8'h0D, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    chk("rst_prio_detected", 110, {31'b0, bus.o_detected}, 32'd1);

    // Masked middle beat: matches only when the mask feature is built in.
    drive(1, 0, 8'h00, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    drive(0, 0, 8'h00, 1, 32'h0A0B0C0D, 32'hFF00FFFF, 0, 0);
    drive(0, 1, 8'h0A, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    drive(0, 1, 8'h55, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    drive(0, 1, 8'h0C, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    chk("mask_armed", 120, {31'b0, bus.o_armed}, 32'd1);
    drive(0, 1, 8'h0D, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
`ifdef PDETECT_MASK_EN
    chk("mask_detected", 121, {31'b0, bus.o_detected}, 32'd1);
    chk("mask_cnt", 122, {16'b0, bus.o_match_cnt}, 32'd1);
`else
    chk("mask_detected", 121, {31'b0, bus.o_detected}, 32'd0);
    chk("mask_cnt", 122, {16'b0, bus.o_match_cnt}, 32'd0);
`endif
    drive(0, 0, 8'h00, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    chk("pulse_width", 123, {31'b0, bus.o_detected}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
